// File: rtl/rv32_regfile_pkg.sv
// rv32_regfile_pkg: shared defaults, width helpers and FSM states for the banked register file.
package rv32_regfile_pkg;
  localparam int XLEN_D      = 32;
  localparam int NUM_HARTS_D = 8;
  localparam int NUM_REGS_D  = 32;
  function automatic int hart_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction
  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
endpackage

// File: rtl/rv32_rf_scoreboard.sv
// rv32_rf_scoreboard: per-register pending-write bits; a set and a clear on the same entry leave it set.
module rv32_rf_scoreboard
  import rv32_regfile_pkg::*;
#(
  parameter int NUM_HARTS  = NUM_HARTS_D,
  parameter int NUM_REGS   = NUM_REGS_D,
  parameter int NUM_RPORTS = 2,
  localparam int HW = hart_w(NUM_HARTS),
  localparam int AW = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [HW-1:0]            set_hart,
  input  logic [AW-1:0]            set_addr,
  input  logic                     clr_en,
  input  logic [HW-1:0]            clr_hart,
  input  logic [AW-1:0]            clr_addr,
  input  logic [HW-1:0]            lk_hart,
  input  logic [NUM_RPORTS*AW-1:0] lk_addr,
  output logic [NUM_RPORTS-1:0]    lk_busy
);
  logic [NUM_HARTS*NUM_REGS-1:0] sb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else begin
      if (clr_en) sb[{clr_hart, clr_addr}] <= 1'b0;
      if (set_en) sb[{set_hart, set_addr}] <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_RPORTS; g++) begin : g_lk
    assign lk_busy[g] = sb[{lk_hart, lk_addr[g*AW +: AW]}];
  end
endmodule

// File: rtl/rv32_mt_regfile.sv
// rv32_mt_regfile: multi-hart RV32 integer register file with zeroing sequencer, bypass and scoreboard.
module rv32_mt_regfile
  import rv32_regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_D,
  parameter int NUM_HARTS  = NUM_HARTS_D,
  parameter int NUM_REGS   = NUM_REGS_D,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1,
  localparam int HW = hart_w(NUM_HARTS),
  localparam int AW = addr_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic                       rd_en,
  input  logic [HW-1:0]              rd_hart,
  input  logic [NUM_RPORTS*AW-1:0]   ra,
  output logic [NUM_RPORTS*XLEN-1:0] rd,
  output logic [NUM_RPORTS-1:0]      rd_busy,
  output logic                       rd_valid,
  input  logic                       wen,
  input  logic [HW-1:0]              w_hart,
  input  logic [AW-1:0]              wa,
  input  logic [XLEN-1:0]            wd,
  input  logic                       sb_set,
  input  logic [HW-1:0]              sb_hart,
  input  logic [AW-1:0]              sb_addr
);
  localparam int N  = NUM_HARTS * NUM_REGS;
  localparam int IW = HW + AW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  rf_state_t state;
  logic [IW-1:0] clr_idx;
  logic ready, w_ok, m_we;
  logic [IW-1:0] m_idx;
  logic [XLEN-1:0] m_wd;
  logic [XLEN-1:0] mem [N];
  logic [NUM_RPORTS-1:0] lk_busy, busy_nxt;
  logic [NUM_RPORTS*XLEN-1:0] rd_nxt;
  logic [AW-1:0] a;
  logic hit;
  assign ready = state == RF_READY;
  assign w_ok  = ready && wen && wa != '0;
  // The sequencer owns the single write port until every entry is zeroed.
  assign m_we  = !ready || w_ok;
  assign m_idx = ready ? {w_hart, wa} : clr_idx;
  assign m_wd  = ready ? wd : '0;
  always_ff @(posedge clk) begin
    if (m_we) mem[m_idx] <= m_wd;
  end
  rv32_rf_scoreboard #(
    .NUM_HARTS(NUM_HARTS), .NUM_REGS(NUM_REGS), .NUM_RPORTS(NUM_RPORTS)
  ) u_sb (
    .clk(clk), .rst(rst),
    .set_en(ready && sb_set && sb_addr != '0), .set_hart(sb_hart), .set_addr(sb_addr),
    .clr_en(w_ok), .clr_hart(w_hart), .clr_addr(wa),
    .lk_hart(rd_hart), .lk_addr(ra), .lk_busy(lk_busy)
  );
  always_comb begin
    rd_nxt   = '0;
    busy_nxt = '0;
    a        = '0;
    hit      = 1'b0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      a   = ra[p*AW +: AW];
      hit = BYPASS != 0 && w_ok && rd_hart == w_hart && a == wa;
      rd_nxt[p*XLEN +: XLEN] = a == '0 ? '0 : hit ? wd : mem[{rd_hart, a}];
      busy_nxt[p] = a != '0 && !hit && lk_busy[p];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RF_CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd        <= '0;
      rd_busy   <= '0;
    end else begin
      if (!ready) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == LAST) begin
          state     <= RF_READY;
          init_done <= 1'b1;
        end
      end
      rd_valid <= ready && rd_en;
      if (ready && rd_en) begin
        rd      <= rd_nxt;
        rd_busy <= busy_nxt;
      end
    end
  end
endmodule

// File: tb/tb_rv32_mt_regfile.sv
// tb_rv32_mt_regfile: scoreboard-driven bench for the multi-hart register file.
module tb_rv32_mt_regfile;
  localparam int XL = 32, NH = 8, NR = 32, NP = 2, BP = 1, HW = 3, AW = 5;
  typedef struct packed {
    logic [NP*XL-1:0] d;
    logic [NP-1:0]    b;
  } exp_t;
  logic clk = 0, rst = 1, init_done, rd_en = 0, rd_valid, wen = 0, sb_set = 0;
  logic [HW-1:0] rd_hart = '0, w_hart = '0, sb_hart = '0;
  logic [NP*AW-1:0] ra = '0;
  logic [NP*XL-1:0] rd;
  logic [NP-1:0] rd_busy;
  logic [AW-1:0] wa = '0, sb_addr = '0;
  logic [XL-1:0] wd = '0;
  logic [XL-1:0] m [NH*NR];
  logic [NH*NR-1:0] sbm;
  exp_t q[$];
  exp_t e_m;
  int total = 0, bad = 0;
  bit rdy = 0;
  always #5 clk = ~clk;
  rv32_mt_regfile #(.XLEN(XL), .NUM_HARTS(NH), .NUM_REGS(NR), .NUM_RPORTS(NP), .BYPASS(BP)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .rd_en(rd_en), .rd_hart(rd_hart), .ra(ra),
    .rd(rd), .rd_busy(rd_busy), .rd_valid(rd_valid), .wen(wen), .w_hart(w_hart), .wa(wa),
    .wd(wd), .sb_set(sb_set), .sb_hart(sb_hart), .sb_addr(sb_addr)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst && rd_valid) begin
      if (q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
      else begin
        e_m = q.pop_front();
        chk("rd", rd, e_m.d);
        chk("rd_busy", 64'(rd_busy), 64'(e_m.b));
      end
    end
  end
  task automatic model_reset();
    for (int i = 0; i < NH*NR; i++) m[i] = '0;
    sbm = '0;
    rdy = 0;
  endtask
  task automatic step(input logic r, input int rh, input int a0, input int a1,
                      input logic w, input int wh, input int wr, input logic [XL-1:0] dv,
                      input logic s, input int sh, input int sr);
    exp_t e;
    int a, ix;
    logic hit;
    rd_en = r; rd_hart = HW'(rh); ra = {AW'(a1), AW'(a0)};
    wen = w; w_hart = HW'(wh); wa = AW'(wr); wd = dv;
    sb_set = s; sb_hart = HW'(sh); sb_addr = AW'(sr);
    if (rdy) begin
      if (r) begin
        e = '0;
        for (int p = 0; p < NP; p++) begin
          a   = p == 0 ? a0 : a1;
          ix  = rh*NR + a;
          hit = BP != 0 && w && rh == wh && a == wr && wr != 0;
          e.d[p*XL +: XL] = a == 0 ? '0 : hit ? dv : m[ix];
          e.b[p] = a != 0 && !hit && sbm[ix];
        end
        q.push_back(e);
      end
      if (w && wr != 0) begin
        m[wh*NR + wr]   = dv;
        sbm[wh*NR + wr] = 1'b0;
      end
      if (s && sr != 0) sbm[sh*NR + sr] = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic count_clear(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      chk("clear_rd_valid", 64'(rd_valid), 64'd0);
    end while (!init_done && n < limit);
  endtask
  task automatic wait_init();
    int n;
    rd_en = 1; rd_hart = 3'd5; ra = {5'd17, 5'd17};
    wen = 1; w_hart = 3'd5; wa = 5'd17; wd = 32'hFFFF_FFFF;
    sb_set = 1; sb_hart = 3'd5; sb_addr = 5'd17;
    count_clear(400, n);
    chk("init_cycles", 64'(n), 64'd256);
    chk("init_done_hi", 64'(init_done), 64'd1);
    @(negedge clk);
    rdy = 1;
    idle(1);
  endtask
  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd", rd, 64'd0);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    rst = 0;
    wait_init();
    step(1, 5, 17, 17, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 5, 32'hDEAD_BEEF, 0, 0, 0);
    step(1, 3, 0, 5, 0, 0, 0, '0, 0, 0, 0);
    step(1, 2, 0, 5, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    step(1, 1, 7, 7, 1, 1, 7, 32'h0000_1234, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 4, 9);
    step(1, 4, 9, 3, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 9, 32'h55, 1, 4, 9);
    step(1, 4, 9, 9, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 9, 32'h66, 0, 0, 0);
    step(1, 4, 9, 0, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 4, 10);
    step(1, 4, 10, 10, 1, 4, 10, 32'h77, 0, 0, 0);
    step(1, 6, 9, 10, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
    idle(3);
    chk("drain1", 64'(q.size()), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 2, 2);
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
    rd_en = 1;
    count_clear(100, n);
    rst = 1;
    #1;
    chk("mid_rst_init_done", 64'(init_done), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    wait_init();
    step(1, 3, 5, 0, 0, 0, 0, '0, 0, 0, 0);
    step(1, 2, 2, 1, 0, 0, 0, '0, 0, 0, 0);
    idle(3);
    chk("drain2", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_mt_regfile.md
Name: rv32_mt_regfile

Overview:
- Banked, multi-hart integer register file for the barrel-threaded RV32 core, with one bank of NUM_REGS registers per hart.
- Provides NUM_RPORTS synchronous read ports, one write port, optional write-to-read bypass, and a per-register pending-write scoreboard.
- After reset, an internal sequencer zeroes every entry before the file accepts traffic.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
- XLEN, 32, data width in bits.
- NUM_HARTS, 8, number of hart banks (power of 2, ≥1).
- NUM_REGS, 32, registers per hart (power of 2); index 0 is hardwired zero.
- NUM_RPORTS, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write is forwarded to reads; 0 = reads return old data.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- init_done  out  1  high once the clear sequence has finished
- rd_en  in  1  read request, applies to all ports
- rd_hart  in  HW  hart id for all read ports; HW = max(1,$clog2(NUM_HARTS))
- ra  in  NUM_RPORTS*AW  read addresses; AW = $clog2(NUM_REGS); port p occupies bits [p*AW +: AW]
- rd  out  NUM_RPORTS*XLEN  read data, packed the same way as ra
- rd_busy  out  NUM_RPORTS  scoreboard bit of each read register, sampled with the data
- rd_valid  out  1  rd/rd_busy valid
- wen  in  1  write enable
- w_hart  in  HW  write hart id
- wa  in  AW  write address
- wd  in  XLEN  write data
- sb_set  in  1  mark (sb_hart, sb_addr) as pending
- sb_hart  in  HW  scoreboard hart id
- sb_addr  in  AW  scoreboard register address

Behaviour:
- Reset (asynchronous, active-high). Forces:
  - FSM to CLEAR; clear index to 0
  - init_done=0, rd_valid=0, rd=0, rd_busy=0
  - all scoreboard bits to 0
- Storage array has no reset; it is zeroed by the sequencer.
- FSM CLEAR:
  - Each cycle writes 0 to the flattened entry {hart,reg}=clr_idx, then increments clr_idx.
  - Takes NUM_HARTS*NUM_REGS cycles (256 at defaults).
  - After the last index, transitions to READY; init_done=1 from that cycle onward.
- While in CLEAR:
  - rd_en, wen and sb_set are ignored.
  - rd_valid stays 0.
- FSM READY is terminal until the next rst. rst asserted mid-clear restarts the sequence from index 0.
- Read (READY only):
  - rd_en sampled at edge N gives rd_valid=1 with rd and rd_busy updated after edge N+1's setup, i.e. one cycle of latency.
  - rd_valid is 0 in cycles with no request; rd holds its last value.
- Register 0:
  - Reads of address 0 return 0 with rd_busy=0.
  - Writes to address 0 are dropped.
  - sb_set to address 0 is ignored.
- Write: when wen=1 and wa≠0, entry (w_hart,wa)←wd at the clock edge.
- Bypass, for the same cycle with rd_en and wen, rd_hart==w_hart, ra_p==wa, wa≠0:
  - BYPASS=1: rd_p=wd, rd_busy_p=0.
  - BYPASS=0: rd_p returns the pre-write value and the pre-clear busy bit.
- Scoreboard:
  - sb_set sets bit (sb_hart,sb_addr).
  - A write with wen clears bit (w_hart,wa).
  - If set and clear hit the same entry in the same cycle, set wins (new producer).
  - Reads report the bit as stored before the edge, subject to the BYPASS rule above.
- Multiple read ports may address the same register; each returns identical data.
- Address and hart fields are used unmodified. Flattened index = hart*NUM_REGS + reg.

Decomposition:
- Package rv32_regfile_pkg holds:
  - the defaults XLEN / NUM_HARTS / NUM_REGS
  - the derived-width helper functions (HW, AW)
  - the FSM state enum {RF_CLEAR, RF_READY}
- One sub-module, rv32_rf_scoreboard: NUM_HARTS*NUM_REGS bits with async reset, one set port, one clear port, and NUM_RPORTS combinational lookups. It applies the set-wins rule.
- The top level contains the storage array, the clear FSM, the read pipeline registers and the bypass muxes.

Test Plan:
- Reset: assert rst for 3 cycles, then release. Required: init_done=0 for exactly 256 cycles, then 1. A read of hart 5 x17 issued afterwards returns 0.
- Basic write/read: write hart 3 x5=0xDEADBEEF; the next cycle read ra={x5,x0} on hart 3. Required: rd_valid one cycle later, rd={0xDEADBEEF,0}. The same read on hart 2 returns 0.
- x0 protection: write hart 0 x0=0xFFFFFFFF with sb_set on x0. Required: a subsequent read of x0 gives rd=0 and rd_busy=0.
- Bypass: same cycle, wen hart1 x7=0x1234 and rd_en hart1 ra0=x7. Required: BYPASS=1 gives rd0=0x1234; BYPASS=0 gives the prior value 0.
- Scoreboard:
  - sb_set hart 4 x9, then read. Required: rd_busy=1.
  - Same cycle sb_set and wen on hart 4 x9. Required: bit stays 1.
  - wen alone on hart 4 x9. Required: bit clears, and the next read shows rd_busy=0.
- Reset mid-clear: assert rst at clear cycle 100. Required: rd_valid stays 0, and the full 256-cycle sequence restarts before init_done=1.
